// File: rtl/trace_retire_buffer.sv
// rtl/trace_retire_buffer.sv - retirement trace FIFO with sequence tagging and drop accounting
module trace_retire_buffer #(
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     trace_valid_i,
    input  logic [31:0]              trace_pc_i,
    input  logic [31:0]              trace_insn_i,
    input  logic                     trace_exception_i,
    input  logic                     trace_interrupt_i,
    input  logic                     clear_i,
    output logic                     rec_valid_o,
    input  logic                     rec_ready_i,
    output logic [31:0]              rec_pc_o,
    output logic [31:0]              rec_insn_o,
    output logic                     rec_compressed_o,
    output logic                     rec_exception_o,
    output logic                     rec_interrupt_o,
    output logic [31:0]              rec_seq_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [CNTW-1:0]          drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        comp;
        logic        exc;
        logic        intr;
        logic [31:0] seq;
    } rec_t;

    rec_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [31:0]     seq_q, seq_d;
    logic            overflow_q, overflow_d;
    logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;
    logic            full, pop, push, drop;
    rec_t            wr_rec, head;

    always_comb begin
        full = (level_q == LW'(DEPTH));
        pop  = (level_q != '0) && rec_ready_i;
        push = trace_valid_i && (!full || pop);
        drop = trace_valid_i && full && !pop;

        wr_rec.pc   = trace_pc_i;
        wr_rec.comp = (trace_insn_i[1:0] != 2'b11);
        wr_rec.insn = wr_rec.comp ? {16'b0, trace_insn_i[15:0]} : trace_insn_i;
        wr_rec.exc  = trace_exception_i;
        wr_rec.intr = trace_interrupt_i;
        wr_rec.seq  = seq_q;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        seq_d    = trace_valid_i ? seq_q + 32'd1 : seq_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A drop coinciding with clear is still counted once after the clear.
        overflow_d = clear_i ? 1'b0 : (overflow_q || drop);
        if (clear_i)
            drop_cnt_d = drop ? CNTW'(1) : '0;
        else if (drop && !(&drop_cnt_q))
            drop_cnt_d = drop_cnt_q + CNTW'(1);
        else
            drop_cnt_d = drop_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= wr_rec;
    end

    assign head = (level_q != '0) ? mem_q[rd_ptr_q] : '0;

    assign rec_valid_o      = (level_q != '0);
    assign rec_pc_o         = head.pc;
    assign rec_insn_o       = head.insn;
    assign rec_compressed_o = head.comp;
    assign rec_exception_o  = head.exc;
    assign rec_interrupt_o  = head.intr;
    assign rec_seq_o        = head.seq;
    assign level_o          = level_q;
    assign overflow_o       = overflow_q;
    assign drop_cnt_o       = drop_cnt_q;
endmodule

// File: tb/tb_trace_retire_buffer.sv
// tb/tb_trace_retire_buffer.sv - randomized self-checking bench for trace_retire_buffer
module tb_trace_retire_buffer;
    localparam int DEPTH = 8;
    localparam int CNTW  = 4;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        trace_valid_i;
    logic [31:0] trace_pc_i, trace_insn_i;
    logic        trace_exception_i, trace_interrupt_i, clear_i, rec_ready_i;
    logic        rec_valid_o;
    logic [31:0] rec_pc_o, rec_insn_o, rec_seq_o;
    logic        rec_compressed_o, rec_exception_o, rec_interrupt_o;
    logic [3:0]  level_o;
    logic        overflow_o;
    logic [CNTW-1:0] drop_cnt_o;

    trace_retire_buffer #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst_l(rst_l),
        .trace_valid_i(trace_valid_i), .trace_pc_i(trace_pc_i), .trace_insn_i(trace_insn_i),
        .trace_exception_i(trace_exception_i), .trace_interrupt_i(trace_interrupt_i),
        .clear_i(clear_i), .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
        .rec_pc_o(rec_pc_o), .rec_insn_o(rec_insn_o), .rec_compressed_o(rec_compressed_o),
        .rec_exception_o(rec_exception_o), .rec_interrupt_o(rec_interrupt_o),
        .rec_seq_o(rec_seq_o), .level_o(level_o), .overflow_o(overflow_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        comp;
        logic        exc;
        logic        intr;
        logic [31:0] seq;
    } mrec_t;

    mrec_t       m_q[$];
    logic [31:0] m_seq;
    logic        m_ovf;
    int          m_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_seq = 0;
        m_ovf = 0;
        m_cnt = 0;
    endtask

    // Applies the behaviour of one clock edge to the reference model.
    task automatic model_edge();
        bit    pop, acc, drp;
        mrec_t r;
        pop = (m_q.size() != 0) && rec_ready_i;
        acc = trace_valid_i && ((m_q.size() < DEPTH) || pop);
        drp = trace_valid_i && !acc;
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            r.pc   = trace_pc_i;
            r.comp = (trace_insn_i[1:0] != 2'b11);
            r.insn = r.comp ? (trace_insn_i & 32'h0000FFFF) : trace_insn_i;
            r.exc  = trace_exception_i;
            r.intr = trace_interrupt_i;
            r.seq  = m_seq;
            m_q.push_back(r);
        end
        if (trace_valid_i) m_seq = m_seq + 1;
        if (clear_i) begin
            m_ovf = 0;
            m_cnt = drp ? 1 : 0;
        end else if (drp) begin
            m_ovf = 1;
            if (m_cnt < (1 << CNTW) - 1) m_cnt++;
        end
    endtask

    task automatic check_all();
        mrec_t h;
        h = '{pc: 0, insn: 0, comp: 0, exc: 0, intr: 0, seq: 0};
        if (m_q.size() != 0) h = m_q[0];
        chk("valid", rec_valid_o, m_q.size() != 0);
        chk("level", level_o, m_q.size());
        chk("overflow", overflow_o, m_ovf);
        chk("drop_cnt", drop_cnt_o, m_cnt);
        chk("pc", rec_pc_o, h.pc);
        chk("insn", rec_insn_o, h.insn);
        chk("comp", rec_compressed_o, h.comp);
        chk("exc", rec_exception_o, h.exc);
        chk("intr", rec_interrupt_o, h.intr);
        chk("seq", rec_seq_o, h.seq);
    endtask

    // Called at a negedge; drives one cycle, advances the model, checks at the next negedge.
    task automatic cyc(input bit v, input logic [31:0] pc, input logic [31:0] insn,
                       input bit rdy, input bit clr);
        trace_valid_i     = v;
        trace_pc_i        = pc;
        trace_insn_i      = insn;
        trace_exception_i = v & pc[4];
        trace_interrupt_i = v & pc[5];
        rec_ready_i       = rdy;
        clear_i           = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        #2 rst_l = 1'b0;
        #1;
        chk("rst_async_valid", rec_valid_o, 1'b0);
        chk("rst_async_level", level_o, 4'd0);
        model_reset();
        @(negedge clk);
        rst_l = 1'b1;
        check_all();
    endtask

    initial begin
        rst_l = 1'b0;
        trace_valid_i = 0; trace_pc_i = 0; trace_insn_i = 0;
        trace_exception_i = 0; trace_interrupt_i = 0; clear_i = 0; rec_ready_i = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        check_all();

        cyc(1, 32'h80000000, 32'h00000013, 1, 0);
        chk("t33_valid", rec_valid_o, 1'b1);
        chk("t33_insn", rec_insn_o, 32'h00000013);
        chk("t33_comp", rec_compressed_o, 1'b0);
        chk("t33_seq", rec_seq_o, 32'd0);
        cyc(0, 0, 0, 1, 0);
        chk("t33_empty", rec_valid_o, 1'b0);

        cyc(1, 32'h80000004, 32'hABCD4501, 1, 0);
        chk("t34_insn", rec_insn_o, 32'h00004501);
        chk("t34_comp", rec_compressed_o, 1'b1);
        cyc(0, 0, 0, 1, 0);

        async_reset();
        for (int i = 0; i < 10; i++) cyc(1, 32'h1000 + 4 * i, 32'h00000013 + (i << 7), 0, 0);
        chk("t35_level", level_o, 4'd8);
        chk("t35_ovf", overflow_o, 1'b1);
        chk("t35_cnt", drop_cnt_o, 4'd2);
        for (int i = 0; i < 8; i++) begin
            chk("t35_drain_seq", rec_seq_o, i);
            cyc(0, 0, 0, 1, 0);
        end
        cyc(1, 32'h2000, 32'h00000033, 0, 0);
        chk("t35_next_seq", rec_seq_o, 32'd10);

        for (int i = 0; i < 7; i++) cyc(1, 32'h3000 + 4 * i, 32'h00000093, 0, 0);
        cyc(1, 32'h4000, 32'h00000013, 1, 0);
        chk("t36_level", level_o, 4'd8);
        chk("t36_cnt", drop_cnt_o, 4'd2);

        cyc(1, 32'h4004, 32'h00000013, 0, 1);
        chk("t37_ovf", overflow_o, 1'b0);
        chk("t37_cnt", drop_cnt_o, 4'd1);
        cyc(0, 0, 0, 0, 1);
        chk("t37_clr", drop_cnt_o, 4'd0);
        chk("t37_level", level_o, 4'd8);

        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        chk("t38_level5", level_o, 4'd5);
        async_reset();
        cyc(1, 32'h5000, 32'h00000013, 0, 0);
        chk("t38_seq", rec_seq_o, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            int  phase;
            bit  v, r, c;
            phase = (i / 200) % 3;
            v = ($urandom_range(99) < (phase == 0 ? 80 : (phase == 1 ? 40 : 60)));
            r = ($urandom_range(99) < (phase == 0 ? 25 : (phase == 1 ? 85 : 55)));
            c = ($urandom_range(99) < 3);
            cyc(v, $urandom, $urandom, r, c);
            if (i == 1500) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/trace_retire_buffer.md
TRACE_RETIRE_BUFFER -- requirements
Module: trace_retire_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count; power of two, 2..64.
REQ-002 SHALL have parameter CNTW, default 16, width of drop counter.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1 (all state on rising edge); rst_l input 1 (asynchronous assert, active-low).
REQ-004 trace_valid_i  input  1  one instruction retired this cycle (core trace port strobe).
REQ-005 trace_pc_i  input  32  PC of retired instruction.
REQ-006 trace_insn_i  input  32  raw instruction bits; upper 16 ignored when compressed.
REQ-007 trace_exception_i  input  1  retirement caused an exception.
REQ-008 trace_interrupt_i  input  1  retirement was interrupted.
REQ-009 clear_i  input  1  synchronous clear of overflow_o and drop_cnt_o.
REQ-010 rec_valid_o  output  1  record available at FIFO head.
REQ-011 rec_ready_i  input  1  tracer accepts record.
REQ-012 rec_pc_o, rec_insn_o  output  32 each  head PC and instruction; rec_insn_o[31:16]=0 for compressed.
REQ-013 rec_compressed_o, rec_exception_o, rec_interrupt_o  output  1 each  head flags.
REQ-014 rec_seq_o  output  32  retirement sequence number of head record.
REQ-015 level_o  output  $clog2(DEPTH)+1  current entry count.
REQ-016 overflow_o  output  1  sticky: at least one retirement dropped.
REQ-017 drop_cnt_o  output  CNTW  number of dropped retirements, saturating.

Function
REQ-018 Compressed detect: trace_insn_i[1:0]!=2'b11 -> compressed=1, stored insn = {16'b0, trace_insn_i[15:0]}; else full 32 bits stored.
REQ-019 Sequence counter (32-bit, reset 0) SHALL increment by 1 on every cycle with trace_valid_i=1, accepted or dropped, wrapping 0xFFFFFFFF->0; each stored record carries pre-increment value.
REQ-020 pop = rec_valid_o & rec_ready_i; push accepted when trace_valid_i=1 and (level<DEPTH or pop).
REQ-021 Full with trace_valid_i=1 and no pop: record dropped, overflow_o<=1, drop_cnt_o increments, saturating at all-ones.
REQ-022 Full with simultaneous push and pop: both occur, level stays DEPTH, no drop.
REQ-023 Empty with push: record visible on rec_* outputs next cycle (latency 1); no combinational path from trace_* to rec_*.
REQ-024 Head outputs SHALL be driven from registered FIFO storage; record held stable while rec_valid_o=1 and rec_ready_i=0.
REQ-025 rec_valid_o = (level!=0); level updates +1 push-only, -1 pop-only, unchanged both/neither.
REQ-026 Read/write pointers wrap modulo DEPTH.
REQ-027 Records SHALL be delivered in retirement order with no duplication.
REQ-028 clear_i=1 SHALL zero overflow_o and drop_cnt_o next edge; if a drop occurs the same cycle, clear wins for overflow_o, drop_cnt_o<=1.
REQ-029 clear_i SHALL NOT affect FIFO contents, level_o, or sequence counter.

Reset
REQ-030 rst_l=0 SHALL asynchronously set pointers, level_o, sequence counter, overflow_o, drop_cnt_o to 0; rec_valid_o=0.
REQ-031 rec_pc_o, rec_insn_o, rec_seq_o, rec flags SHALL read 0 while level_o=0 after reset.
REQ-032 Reset mid-operation discards all buffered records; first retirement after release gets rec_seq_o=0.

Verification
REQ-033 Empty, rec_ready_i=1, one strobe pc=0x80000000 insn=0x00000013 -> next cycle rec_valid_o=1, rec_insn_o=0x00000013, compressed=0, seq=0; following cycle rec_valid_o=0.
REQ-034 Strobe insn=0xABCD4501 -> rec_insn_o=0x00004501, rec_compressed_o=1.
REQ-035 DEPTH=8, rec_ready_i=0, 10 consecutive strobes -> level_o=8, overflow_o=1, drop_cnt_o=2; drain yields seq 0..7 in order, next strobe carries seq 10.
REQ-036 Full, rec_ready_i=1 and strobe same cycle -> no drop, level_o stays 8, drop_cnt_o unchanged.
REQ-037 Drop with clear_i=1 same cycle -> overflow_o=0, drop_cnt_o=1; clear_i alone -> drop_cnt_o=0.
REQ-038 rst_l pulsed low mid-stream with 5 entries -> rec_valid_o=0 and level_o=0 immediately (asynchronous); next strobe after release gives rec_seq_o=0.
